// File: rtl/retire_stage_pkg.sv
// Shared types and sizing for the retire stage and its neighbours.
package retire_stage_pkg;

    localparam int unsigned SUPERSCALAR_WAYS = 2;
    localparam int unsigned N_ARCH_REG       = 32;
    localparam int unsigned N_ARCH_REG_BITS  = 5;
    localparam int unsigned N_PHYS_REG_BITS  = 6;
    localparam int unsigned XLEN             = 32;

    // One retiring ROB entry; meaningful only when complete = 1.
    typedef struct packed {
        logic                       complete;
        logic [N_ARCH_REG_BITS-1:0] ar_idx;
        logic [N_PHYS_REG_BITS-1:0] t_idx;
        logic [N_PHYS_REG_BITS-1:0] told_idx;
        logic                       precise_state_enable;
        logic                       halt;
        logic [XLEN-1:0]            target_pc;
    } rob_packet_t;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StRestore,
        StHalted
    } retire_state_e;

endpackage

// File: rtl/retire_stage_if.sv
// Bundle between the ROB, the retire stage and its consumers.
import retire_stage_pkg::*;

interface retire_stage_if;
    rob_packet_t [SUPERSCALAR_WAYS-1:0]                      rob_retire_in;
    logic        [SUPERSCALAR_WAYS-1:0]                      free_valid;
    logic        [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] free_idx;
    logic        [N_ARCH_REG-1:0][N_PHYS_REG_BITS-1:0]       arch_map;
    logic                                                    squash;
    logic        [XLEN-1:0]                                  redirect_pc;
    logic                                                    restore_en;
    logic                                                    halted;
    logic        [63:0]                                      retired_count;

    // Retire stage side.
    modport slave (
        input  rob_retire_in,
        output free_valid, free_idx, arch_map, squash, redirect_pc, restore_en, halted,
               retired_count
    );

    // ROB / consumer side.
    modport master (
        output rob_retire_in,
        input  free_valid, free_idx, arch_map, squash, redirect_pc, restore_en, halted,
               retired_count
    );
endinterface

// File: rtl/retire_stage_arch_map_table.sv
// Committed architectural map table; later write ports win on address collisions.
module arch_map_table
    import retire_stage_pkg::*;
(
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic [SUPERSCALAR_WAYS-1:0]                        we_i,
    input  logic [SUPERSCALAR_WAYS-1:0][N_ARCH_REG_BITS-1:0]   waddr_i,
    input  logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0]   wdata_i,
    output logic [N_ARCH_REG-1:0][N_PHYS_REG_BITS-1:0]         map_o
);

    logic [N_ARCH_REG-1:0][N_PHYS_REG_BITS-1:0] map_q, map_d;

    // Apply writes in way order so the youngest way's value lands last.
    always_comb begin
        map_d = map_q;
        for (int unsigned w = 0; w < SUPERSCALAR_WAYS; w++) begin
            if (we_i[w]) begin
                map_d[waddr_i[w]] = wdata_i[w];
            end
        end
    end

    // Storage; reset maps every architectural register to its own physical index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ARCH_REG; i++) begin
                map_q[i] <= N_PHYS_REG_BITS'(i);
            end
        end else begin
            map_q <= map_d;
        end
    end

    assign map_o = map_q;

endmodule

// File: rtl/retire_stage.sv
// In-order retirement: commits the AMT, frees old physical registers and
// sequences the flush/restore handshake after a precise-state event.
module retire_stage
    import retire_stage_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    retire_stage_if.slave bus
);

    retire_state_e state_q, state_d;

    logic [SUPERSCALAR_WAYS-1:0]                      free_valid_q, free_valid_d;
    logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] free_idx_q, free_idx_d;
    logic                                             squash_q, squash_d;
    logic                                             restore_en_q, restore_en_d;
    logic [XLEN-1:0]                                  redirect_pc_q, redirect_pc_d;
    logic                                             halted_q, halted_d;
    logic [63:0]                                      retired_count_q, retired_count_d;

    logic [SUPERSCALAR_WAYS-1:0]                      amt_we;
    logic [SUPERSCALAR_WAYS-1:0][N_ARCH_REG_BITS-1:0] amt_waddr;
    logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] amt_wdata;

    // Write address/data follow the ways directly; only the enables are gated.
    always_comb begin
        for (int unsigned w = 0; w < SUPERSCALAR_WAYS; w++) begin
            amt_waddr[w] = bus.rob_retire_in[w].ar_idx;
            amt_wdata[w] = bus.rob_retire_in[w].t_idx;
        end
    end

    // Next-state and registered-output logic for the retire FSM.
    always_comb begin
        logic        stop;
        int unsigned n_retired;

        state_d         = state_q;
        free_valid_d    = '0;
        free_idx_d      = '0;
        squash_d        = 1'b0;
        restore_en_d    = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        halted_d        = halted_q;
        retired_count_d = retired_count_q;
        amt_we          = '0;
        stop            = 1'b0;
        n_retired       = 0;

        unique case (state_q)
            StRun: begin
                for (int unsigned w = 0; w < SUPERSCALAR_WAYS; w++) begin
                    // A halt or precise-state way closes the group; younger ways are dropped.
                    if (!stop && bus.rob_retire_in[w].complete) begin
                        n_retired = n_retired + 1;
                        if (bus.rob_retire_in[w].ar_idx != '0) begin
                            amt_we[w]       = 1'b1;
                            free_valid_d[w] = 1'b1;
                            free_idx_d[w]   = bus.rob_retire_in[w].told_idx;
                        end
                        if (bus.rob_retire_in[w].halt) begin
                            state_d  = StHalted;
                            halted_d = 1'b1;
                            stop     = 1'b1;
                        end else if (bus.rob_retire_in[w].precise_state_enable) begin
                            state_d       = StFlush;
                            squash_d      = 1'b1;
                            redirect_pc_d = bus.rob_retire_in[w].target_pc;
                            stop          = 1'b1;
                        end
                    end
                end
                retired_count_d = retired_count_q + 64'(n_retired);
            end
            StFlush: begin
                state_d      = StRestore;
                restore_en_d = 1'b1;
            end
            StRestore: begin
                state_d = StRun;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StRun;
            free_valid_q    <= '0;
            free_idx_q      <= '0;
            squash_q        <= 1'b0;
            restore_en_q    <= 1'b0;
            redirect_pc_q   <= '0;
            halted_q        <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            free_valid_q    <= free_valid_d;
            free_idx_q      <= free_idx_d;
            squash_q        <= squash_d;
            restore_en_q    <= restore_en_d;
            redirect_pc_q   <= redirect_pc_d;
            halted_q        <= halted_d;
            retired_count_q <= retired_count_d;
        end
    end

    arch_map_table u_amt (
        .clock   (clock),
        .reset   (reset),
        .we_i    (amt_we),
        .waddr_i (amt_waddr),
        .wdata_i (amt_wdata),
        .map_o   (bus.arch_map)
    );

    assign bus.free_valid    = free_valid_q;
    assign bus.free_idx      = free_idx_q;
    assign bus.squash        = squash_q;
    assign bus.restore_en    = restore_en_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.halted        = halted_q;
    assign bus.retired_count = retired_count_q;

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1; asynchronous, active-high.
REQ-003 SHALL have port rob_retire_in, input, ROB_PACKET [`SUPERSCALAR_WAYS-1:0]; way i carries a retiring entry iff its complete field = 1; ways are in program order, way 0 oldest.
REQ-004 SHALL have port free_valid, output, [`SUPERSCALAR_WAYS-1:0]; way i returns a physical register to the free list.
REQ-005 SHALL have port free_idx, output, [`SUPERSCALAR_WAYS-1:0][`N_PHYS_REG_BITS-1:0]; the returned register (told_idx).
REQ-006 SHALL have port arch_map, output, [`N_ARCH_REG-1:0][`N_PHYS_REG_BITS-1:0]; the committed architectural map table (AMT).
REQ-007 SHALL have port squash, output, 1; single-cycle pipeline flush request.
REQ-008 SHALL have port redirect_pc, output, [`XLEN-1:0]; fetch target, valid while squash = 1.
REQ-009 SHALL have port restore_en, output, 1; the rename map table loads arch_map this cycle.
REQ-010 SHALL have port halted, output, 1; sticky after a halt retires.
REQ-011 SHALL have port retired_count, output, [63:0]; count of committed instructions.

Function
REQ-012 SHALL register every output; each response appears exactly one cycle after the input cycle that caused it.
REQ-013 SHALL implement FSM RUN, FLUSH, RESTORE, HALTED.
REQ-014 In RUN, for each valid way, in way order, SHALL apply: if ar_idx != 0, set AMT[ar_idx] = t_idx and assert free_valid/free_idx = told_idx; if ar_idx = 0, no AMT write and no free.
REQ-015 SHALL give the higher way priority when two valid ways in one cycle target the same ar_idx; both told_idx values are still freed.
REQ-016 SHALL process ways in order up to and including the first way with precise_state_enable = 1 or halt = 1; valid ways above it SHALL be ignored: no AMT write, no free, not counted.
REQ-017 For a processed way with precise_state_enable = 1, SHALL commit it per REQ-014, capture target_pc into redirect_pc, and go RUN -> FLUSH.
REQ-018 In FLUSH, SHALL assert squash = 1 for exactly one cycle, ignore rob_retire_in, then go FLUSH -> RESTORE.
REQ-019 In RESTORE, SHALL assert restore_en = 1 for exactly one cycle, with arch_map already reflecting the mispredicted instruction's commit, ignore rob_retire_in, then go RESTORE -> RUN.
REQ-020 For a processed way with halt = 1, SHALL commit it per REQ-014 and go to HALTED; halt takes precedence if precise_state_enable is also set on the same way.
REQ-021 In HALTED, SHALL hold halted = 1 and ignore all inputs until reset.
REQ-022 SHALL add the number of processed valid ways (0..`SUPERSCALAR_WAYS) to retired_count each cycle, wrapping modulo 2^64.
REQ-023 SHALL deassert free_valid, squash and restore_en in every cycle with no corresponding event.
REQ-024 SHALL treat way i with complete = 0 as empty regardless of other fields, including when a higher way is valid.

Reset
REQ-025 On reset, SHALL go to RUN with AMT[i] = i for every i, free_valid = 0, free_idx = 0, squash = 0, restore_en = 0, redirect_pc = 0, halted = 0, retired_count = 0.
REQ-026 Reset asserted mid-FLUSH or mid-RESTORE SHALL abort the sequence immediately with no further squash or restore_en pulse.

Structure
REQ-027 SHALL take ROB_PACKET, `SUPERSCALAR_WAYS, `N_ARCH_REG, `N_PHYS_REG_BITS and `XLEN from the shared package/header; SHALL add a RETIRE_STATE enum there.
REQ-028 SHALL contain one sub-module, arch_map_table, holding AMT storage with `SUPERSCALAR_WAYS ordered write ports and reset-to-identity behaviour.

Verification
REQ-029 Reset -> arch_map[5] = 5, halted = 0, retired_count = 0.
REQ-030 Way0 {ar 3, t 40, told 3}, way1 {ar 3, t 41, told 40} in one cycle -> next cycle arch_map[3] = 41, free_idx = {40, 3} with both valid, retired_count += 2.
REQ-031 Way0 precise_state_enable with target_pc 0x100, way1 valid -> way1 ignored; next cycle squash = 1 with redirect_pc = 0x100; the cycle after restore_en = 1; then RUN.
REQ-032 Way0 halt = 1 -> halted = 1 next cycle; later retires change neither arch_map nor retired_count.
REQ-033 Way0 ar_idx = 0 with t 50 -> arch_map[0] unchanged, free_valid[0] = 0, retired_count += 1.
REQ-034 Reset asserted in the FLUSH cycle -> squash and restore_en stay 0, and AMT returns to identity.
